// File: rtl/counter_pkg.sv
// counter_pkg: shared constants and helpers for the counter block.
//   DEFAULT_WIDTH       : default counter width (8 bits)
//   DEFAULT_RESET_VALUE : default value loaded on reset (0)
//   all_ones(width)     : all-ones pattern of the given width, zero-extended to 64 bits
package counter_pkg;

  localparam int          DEFAULT_WIDTH       = 8;
  localparam logic [63:0] DEFAULT_RESET_VALUE = 64'd0;

  // Valid for width in 1..64; a right shift avoids the 64-bit left-shift overflow case.
  function automatic logic [63:0] all_ones(input int width);
    logic [63:0] ones;
    ones = {64{1'b1}};
    return ones >> (64 - width);
  endfunction

endpackage : counter_pkg

// File: rtl/counter_next.sv
// counter_next: combinational next-state logic for the counter.
// Priority: rst, then load, then inc, then hold.
// Optional feature macro: COUNTER_SATURATE_EN (hold at all ones instead of wrapping).
// Ports:
//   rst       in  synchronous reset request (selects RESET_VALUE)
//   load      in  parallel-load strobe
//   inc       in  count enable
//   d         in  parallel-load data [WIDTH-1:0]
//   q         in  current count [WIDTH-1:0]
//   q_next    out next count [WIDTH-1:0]
//   wrap_next out next value of the rollover pulse
module counter_next
  import counter_pkg::*;
#(
  parameter int          WIDTH       = DEFAULT_WIDTH,
  parameter logic [63:0] RESET_VALUE = DEFAULT_RESET_VALUE
) (
  input  logic             rst,
  input  logic             load,
  input  logic             inc,
  input  logic [WIDTH-1:0] d,
  input  logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] q_next,
  output logic             wrap_next
);

  localparam logic [WIDTH-1:0] RST_VAL = RESET_VALUE[WIDTH-1:0];

  // Increment at WIDTH+1 bits; the top bit is the carry-out marking rollover.
  logic [WIDTH:0] sum;

  always_comb begin
    sum       = {1'b0, q} + {{WIDTH{1'b0}}, 1'b1};
    q_next    = q;
    wrap_next = 1'b0;
    if (rst) begin
      q_next = RST_VAL;
    end else if (load) begin
      q_next = d;
    end else if (inc) begin
`ifdef COUNTER_SATURATE_EN
      // At all ones the carry is set: stay put and never signal a wrap.
      if (!sum[WIDTH]) begin
        q_next = sum[WIDTH-1:0];
      end
`else
      q_next    = sum[WIDTH-1:0];
      wrap_next = sum[WIDTH];
`endif
    end
  end

endmodule : counter_next

// File: rtl/counter.sv
// counter: loadable, parameterised-width up-counter with count enable.
// Optional feature macro: COUNTER_SATURATE_EN (saturate at all ones instead of wrapping).
// Ports:
//   clk  in  rising-edge clock
//   rst  in  synchronous active-high reset (q <= RESET_VALUE, wrap <= 0)
//   load in  parallel-load strobe
//   inc  in  count enable
//   d    in  parallel-load data [WIDTH-1:0]
//   q    out registered count [WIDTH-1:0]
//   tc   out terminal count, high while q is all ones
//   wrap out registered one-cycle pulse after an inc-driven rollover to 0
module counter
  import counter_pkg::*;
#(
  parameter int          WIDTH       = DEFAULT_WIDTH,
  parameter logic [63:0] RESET_VALUE = DEFAULT_RESET_VALUE
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             inc,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             wrap
);

  localparam logic [63:0]      ONES_64 = all_ones(WIDTH);
  localparam logic [WIDTH-1:0] ONES    = ONES_64[WIDTH-1:0];

  logic [WIDTH-1:0] q_next;
  logic             wrap_next;

  counter_next #(
    .WIDTH       (WIDTH),
    .RESET_VALUE (RESET_VALUE)
  ) u_next (
    .rst       (rst),
    .load      (load),
    .inc       (inc),
    .d         (d),
    .q         (q),
    .q_next    (q_next),
    .wrap_next (wrap_next)
  );

  // rst is resolved in counter_next, so it takes effect only at this edge.
  always_ff @(posedge clk) begin
    q    <= q_next;
    wrap <= wrap_next;
  end

  assign tc = (q == ONES);

endmodule : counter

// File: tb/tb_counter.sv
// tb_counter: directed self-checking bench for counter.
// Instances: 8-bit/RESET_VALUE=0, 8-bit/RESET_VALUE=5, 1-bit.
// Honours COUNTER_SATURATE_EN for the expected wrap behaviour.
module tb_counter;

  logic       clk = 1'b0;
  logic       rst, load, inc;
  logic [7:0] d;

  logic [7:0] q;
  logic       tc, wrap;
  logic [7:0] q5;
  logic       tc5, wrap5;
  logic [0:0] q1;
  logic       tc1, wrap1;

  int errors = 0;
  int checks = 0;

`ifdef COUNTER_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  always #5 clk = ~clk;

  counter #(.WIDTH(8), .RESET_VALUE(64'd0)) dut (
    .clk(clk), .rst(rst), .load(load), .inc(inc), .d(d),
    .q(q), .tc(tc), .wrap(wrap)
  );

  counter #(.WIDTH(8), .RESET_VALUE(64'd5)) dut5 (
    .clk(clk), .rst(rst), .load(load), .inc(inc), .d(d),
    .q(q5), .tc(tc5), .wrap(wrap5)
  );

  counter #(.WIDTH(1), .RESET_VALUE(64'd0)) dut1 (
    .clk(clk), .rst(rst), .load(load), .inc(inc), .d(d[0:0]),
    .q(q1), .tc(tc1), .wrap(wrap1)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end else begin
      $display("ok   %s: %0d", tag, got);
    end
  endtask

  // Advance one clock and settle just after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic r, input logic l, input logic i, input logic [7:0] dv);
    rst = r; load = l; inc = i; d = dv;
  endtask

  initial begin
    drive(1'b1, 1'b0, 1'b0, 8'd0);
    step(); step();
    check("reset_q", q, 0);
    check("reset_wrap", wrap, 0);
    check("reset_tc", tc, 0);
    check("reset5_q", q5, 5);
    check("reset5_tc", tc5, 0);
    check("reset1_q", q1, 0);

    // Count 20 from 0, then hold.
    drive(1'b0, 1'b0, 1'b1, 8'd0);
    step();
    check("count_first", q, 1);
    for (int i = 0; i < 19; i++) step();
    check("count_20", q, 20);
    check("count5_25", q5, 25);
    drive(1'b0, 1'b0, 1'b0, 8'd0);
    for (int i = 0; i < 5; i++) step();
    check("hold_20", q, 20);
    check("hold_wrap", wrap, 0);

    // Load then count.
    drive(1'b0, 1'b1, 1'b0, 8'd123);
    step();
    check("load_123", q, 123);
    drive(1'b0, 1'b0, 1'b1, 8'd0);
    step();
    check("inc_124", q, 124);
    step();
    check("inc_125", q, 125);

    // Rollover (or saturation).
    drive(1'b0, 1'b1, 1'b0, 8'd254);
    step();
    check("load_254", q, 254);
    check("tc_254", tc, 0);
    drive(1'b0, 1'b0, 1'b1, 8'd0);
    step();
    check("wrap_q255", q, 255);
    check("wrap_tc255", tc, 1);
    check("wrap_pre", wrap, 0);
    step();
    check("wrap_q0", q, SAT ? 255 : 0);
    check("wrap_pulse", wrap, SAT ? 0 : 1);
    check("wrap_tc0", tc, SAT ? 1 : 0);
    step();
    check("wrap_q1", q, SAT ? 255 : 1);
    check("wrap_gone", wrap, 0);

    // Hold at all ones never pulses wrap.
    drive(1'b0, 1'b1, 1'b0, 8'd255);
    step();
    drive(1'b0, 1'b0, 1'b0, 8'd0);
    step();
    check("hold255_q", q, 255);
    check("hold255_wrap", wrap, 0);

    // Load beats inc, even at all ones.
    drive(1'b0, 1'b1, 1'b1, 8'd3);
    step();
    check("load_over_inc_ff", q, 3);
    check("load_over_inc_wrap", wrap, 0);
    drive(1'b0, 1'b1, 1'b1, 8'd77);
    step();
    check("prio_load_77", q, 77);
    // Reset beats load.
    drive(1'b1, 1'b1, 1'b0, 8'd77);
    step();
    check("prio_rst_q", q, 0);
    check("prio_rst5_q", q5, 5);

    // Reset beats inc at all ones: no wrap pulse.
    drive(1'b0, 1'b1, 1'b0, 8'd255);
    step();
    drive(1'b1, 1'b0, 1'b1, 8'd0);
    step();
    check("rst_at_ff_q", q, 0);
    check("rst_at_ff_wrap", wrap, 0);

    // Reset mid-count.
    drive(1'b0, 1'b1, 1'b0, 8'd38);
    step();
    drive(1'b0, 1'b0, 1'b1, 8'd0);
    step(); step();
    check("mid_q40", q, 40);
    drive(1'b1, 1'b0, 1'b1, 8'd0);
    step();
    check("mid_rst_q", q, 0);
    drive(1'b0, 1'b0, 1'b1, 8'd0);
    step();
    check("mid_resume_q", q, 1);

    // WIDTH=1 toggle.
    drive(1'b1, 1'b0, 1'b0, 8'd0);
    step();
    check("w1_rst_q", q1, 0);
    check("w1_rst_tc", tc1, 0);
    drive(1'b0, 1'b0, 1'b1, 8'd0);
    step();
    check("w1_q1", q1, 1);
    check("w1_tc1", tc1, 1);
    step();
    check("w1_q0", q1, SAT ? 1 : 0);
    check("w1_wrap", wrap1, SAT ? 0 : 1);
    step();
    check("w1_q1b", q1, 1);
    check("w1_wrap_gone", wrap1, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_counter
